check_node_serial_min_sum: RTL
==============================

# check_node_serial_min_sum

Serial min-sum check-node processor for the belief-propagation LDPC decoder. It accepts DEG variable-to-check messages, one per cycle, and tracks the minimum magnitude, its index, the second minimum and the sign parity. It then streams DEG check-to-variable messages back out under a valid/ready handshake. It consumes the edge-indexed message stream and hands results to the variable-node update stage.

## Interface
- DEG, default 32: check-node degree; legal range 2..63, so indices fit in 6 bits.
- W, default 5: magnitude width; messages are sign-magnitude, W+1 bits with the sign in bit W.
- OFFSET, default 0: offset-min-sum correction subtracted from each output magnitude.

- clk  input  1  clock, rising edge.
- reset  input  1  reset, asynchronous, active-high.
- start  input  1  one-cycle pulse that begins a new check-node update; honoured only in IDLE.
- in_valid  input  1  in_msg is valid this cycle.
- in_ready  output  1  high while in COLLECT.
- in_msg  input  W+1  incoming variable-to-check message: bit W is the sign (1 = negative), bits W-1:0 are the magnitude.
- out_valid  output  1  high while in EMIT.
- out_ready  input  1  downstream accepts out_msg this cycle.
- out_msg  output  W+1  check-to-variable message for edge out_index.
- out_index  output  6  edge index of out_msg, 0..DEG-1.
- busy  output  1  high in COLLECT or EMIT.
- done  output  1  one-cycle pulse registered on the final output transfer.

## Operation
- States:
  - IDLE -> COLLECT on start.
  - COLLECT -> EMIT after the DEG-th accepted input.
  - EMIT -> IDLE after the DEG-th output transfer.
- Entering COLLECT initialises the accumulators:
  - min1 = min2 = 2^W-1
  - min_idx = 0
  - parity = 0
  - in_cnt = 0
- Input accept: in_valid && in_ready. Each accepted message is edge in_cnt, and in_cnt increments by 1 per accept.
- On each accept, with m the input magnitude and s its sign:
  - sign_reg[in_cnt] <= s
  - parity <= parity ^ s
  - if m < min1 (strict): min2 <= min1, min1 <= m, min_idx <= in_cnt
  - else if m < min2: min2 <= m
  - else: no change to the minima
- Ties: a magnitude equal to min1 never replaces min1 or min_idx. It becomes min2 if it is smaller than the current min2. The earliest index of the minimum therefore wins.
- Output for edge k:
  - magnitude = (k == min_idx ? min2 : min1), minus OFFSET, saturating at 0
  - sign = parity ^ sign_reg[k]
  - if the final magnitude is 0, the sign is forced to 0
- Output transfer: out_valid && out_ready. out_index starts at 0 and increments by 1 per transfer.
- All arithmetic is unsigned on W bits, with no wrap. The index counters are 6 bits and stop at DEG-1.

## Timing
- Reset values:
  - state = IDLE
  - in_ready, out_valid, busy, done = 0
  - out_index = 0, and out_msg = 0 while in IDLE
  - min1 = min2 = all ones
  - min_idx, parity, sign_reg = 0
- start sampled high in IDLE makes in_ready high from the next cycle. start in COLLECT or EMIT is ignored.
- Input stall: in_valid may be low for any number of cycles in COLLECT; nothing changes while it is low.
- The cycle after the DEG-th accept, state is EMIT and out_valid = 1. In_ready is low in that same cycle.
- Minimum latency from the first input to the first output is DEG cycles.
- out_msg and out_index are driven combinationally from registered state. They must hold stable while out_valid && !out_ready.
- On the transfer with out_index == DEG-1:
  - the next cycle, state = IDLE and done = 1 for exactly one cycle
  - out_valid drops in that same next cycle
- start may arrive in the same cycle that done is high, since the block is already in IDLE.
- Reset asserted mid-COLLECT or mid-EMIT aborts immediately to the reset values. No partial output follows.

## Test plan
- DEG=4, W=5, OFFSET=0; inputs +3, -1, +7, -2 with in_valid continuous and out_ready high -> outputs +1, -2, +1, -1 on indices 0..3; done pulses once after index 3.
- Tie: inputs +4, +4, +9, +6 -> min_idx=0, min2=4; all four outputs +4.
- OFFSET=1, same inputs as the first scenario -> outputs +0, -1, +0, +0; every zero magnitude has its sign forced to 0.
- Backpressure and input gaps: in_valid low for 2 cycles between inputs, out_ready low for 3 cycles at index 1 -> same values as the first scenario; out_msg/out_index stay stable while stalled; no duplicated or skipped index.
- start pulsed during COLLECT and during EMIT -> ignored, with the results unchanged. Back-to-back start on the done cycle -> the second update's results are correct, with the accumulators freshly initialised.
- reset asserted after 2 inputs are accepted -> all outputs go to their reset values asynchronously. A following start with inputs -5, -5, -5, -5 -> all four outputs -5 (parity 0, own sign 1).

Source files
------------

// File: rtl/check_node_serial_min_sum.sv
// Serial min-sum check-node processor: collects DEG sign-magnitude messages,
// tracks min1/min2/min_idx/parity, then streams DEG extrinsic messages out.
module check_node_serial_min_sum #(
    parameter int DEG    = 32,
    parameter int W      = 5,
    parameter int OFFSET = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   in_msg,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_msg,
    output logic [5:0]   out_index,
    output logic         busy,
    output logic         done
);

    localparam int             IW      = (DEG > 1) ? $clog2(DEG) : 1;
    localparam logic [5:0]     LAST    = 6'(DEG - 1);
    localparam logic [W-1:0]   MAG_MAX = '1;
    localparam logic [W-1:0]   OFF     = W'(OFFSET);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        EMIT
    } state_t;

    state_t           state;
    logic [5:0]       in_cnt;
    logic [5:0]       out_cnt;
    logic [W-1:0]     min1;
    logic [W-1:0]     min2;
    logic [5:0]       min_idx;
    logic             parity;
    logic [DEG-1:0]   sign_reg;

    logic             in_fire;
    logic             out_fire;
    logic [W-1:0]     in_mag;
    logic             in_sign;
    logic [W-1:0]     sel_mag;
    logic [W-1:0]     out_mag;
    logic             out_sign;

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign in_mag    = in_msg[W-1:0];
    assign in_sign   = in_msg[W];
    assign out_index = out_cnt;

    // NOTE: every register here uses <= so all updates see pre-edge values;
    // the small sign store is reset too because the block has no init pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_cnt    <= '0;
            out_cnt   <= '0;
            min1      <= MAG_MAX;
            min2      <= MAG_MAX;
            min_idx   <= '0;
            parity    <= 1'b0;
            sign_reg  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        min1     <= MAG_MAX;
                        min2     <= MAG_MAX;
                        min_idx  <= '0;
                        parity   <= 1'b0;
                        in_cnt   <= '0;
                    end
                end
                COLLECT: begin
                    if (in_fire) begin
                        sign_reg[in_cnt[IW-1:0]] <= in_sign;
                        parity                   <= parity ^ in_sign;
                        // Strict compare: an equal magnitude keeps the earliest index as min1.
                        if (in_mag < min1) begin
                            min2    <= min1;
                            min1    <= in_mag;
                            min_idx <= in_cnt;
                        end else if (in_mag < min2) begin
                            min2 <= in_mag;
                        end
                        if (in_cnt == LAST) begin
                            state     <= EMIT;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_cnt   <= '0;
                        end else begin
                            in_cnt <= in_cnt + 6'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_fire) begin
                        if (out_cnt == LAST) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            out_cnt   <= '0;
                        end else begin
                            out_cnt <= out_cnt + 6'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Extrinsic message: exclude the edge's own contribution to min and parity.
    always_comb begin
        sel_mag  = (out_cnt == min_idx) ? min2 : min1;
        out_mag  = (sel_mag > OFF) ? (sel_mag - OFF) : '0;
        out_sign = (out_mag != '0) && (parity ^ sign_reg[out_cnt[IW-1:0]]);
        out_msg  = (state == EMIT) ? {out_sign, out_mag} : '0;
    end

endmodule
